// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default baud divisor.
package uart_pkg;

    // 115200 baud from a 100 MHz clock.
    localparam int DEFAULT_CLOCKS_PER_BAUD = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-stream handshake plus status pulses between the UART receiver and its consumer.
//
// Handshake: the producer raises valid with data and holds both stable until a
// cycle where valid && ready; that cycle is the transfer. ready is ignored while
// valid is low. frame_err and overrun are single-cycle pulses, busy is a level.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output data,
        output valid,
        input  ready,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Capture the async input, then let it settle through a second flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       clk_100mhz,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    // Counter only ever reaches CLOCKS_PER_BAUD-1, so ceil(log2) bits never wrap.
    localparam int            CW       = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLOCKS_PER_BAUD - 1);

    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          rxs;

    // Idle line is high, so the synchronizer resets to 1 to avoid a false start bit.
    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_100mhz),
        .rst_i (sys_rst),
        .d_i   (uart_rxd),
        .q_o   (rxs)
    );

    // Receive FSM, bit shifter and the held-byte output register in one place.
    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // Consumer took the held byte; a completing byte below may reload it.
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        // Line back high at mid start bit means it was only a glitch.
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_CNT) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rxs) begin
                            // Load only if the slot is free or being freed this cycle.
                            if (!valid_q || ready_i) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 868 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = DEFAULT_CLOCKS_PER_BAUD;
    // Falling edge to first valid_o: 2 sync flops + 1 IDLE->START + 434 half bit + 9*868.
    localparam int LAT = 8249;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(
        .CLOCKS_PER_BAUD(CPB)
    ) dut (
        .clk_100mhz  (clk),
        .sys_rst     (rst),
        .uart_rxd    (rxd),
        .data_o      (u_if.data),
        .valid_o     (u_if.valid),
        .ready_i     (u_if.ready),
        .frame_err_o (u_if.frame_err),
        .overrun_o   (u_if.overrun),
        .busy_o      (u_if.busy)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Monitor state, sampled 2 ns after each rising edge.
    int         cyc        = 0;
    int         fall_cyc   = 0;
    int         rise_cyc   = 0;
    int         ovr_cyc    = 0;
    int         valid_hi   = 0;
    int         rise_cnt   = 0;
    int         ferr_cnt   = 0;
    int         ovr_cnt    = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Output monitor: counts pulses and captures each new byte.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #2;
        if (!rst) begin
            if (u_if.valid) valid_hi = valid_hi + 1;
            if (u_if.valid && !valid_prev) begin
                rise_cnt = rise_cnt + 1;
                rise_cyc = cyc;
                got_q.push_back(u_if.data);
            end
            if (u_if.frame_err) ferr_cnt = ferr_cnt + 1;
            if (u_if.overrun) begin
                ovr_cnt = ovr_cnt + 1;
                ovr_cyc = cyc;
            end
        end
        valid_prev = u_if.valid;
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) fall_cyc = cyc;
            rxd = bits[i];
            tick(CPB);
        end
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 'x;
            if (got_q.size() > 0) g = got_q.pop_front();
            check({tag, "_byte"}, g, e);
        end
        got_q.delete();
    endtask

    int v0, f0, o0, r0;

    initial begin
        u_if.ready = 1'b1;
        rst = 1'b1;
        rxd = 1'b1;
        tick(4);
        check("rst_data", u_if.data, 8'h00);
        check("rst_valid", u_if.valid, 1'b0);
        check("rst_ferr", u_if.frame_err, 1'b0);
        check("rst_ovr", u_if.overrun, 1'b0);
        check("rst_busy", u_if.busy, 1'b0);
        rst = 1'b0;
        tick(20);

        // Single byte, consumer always ready.
        v0 = valid_hi; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(10);
        score("a5");
        check("a5_latency", rise_cyc - fall_cyc, LAT);
        check("a5_valid_cycles", valid_hi - v0, 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_ovr", ovr_cnt - o0, 0);
        check("a5_busy", u_if.busy, 1'b0);

        // Consumer stalled: second byte dropped with an overrun pulse.
        u_if.ready = 1'b0;
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        tick(10);
        score("ovr");
        check("ovr_data_held", u_if.data, 8'h3C);
        check("ovr_valid_held", u_if.valid, 1'b1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_latency", ovr_cyc - fall_cyc, LAT);
        check("ovr_ferr", ferr_cnt - f0, 0);
        u_if.ready = 1'b1;
        tick(1);
        check("ovr_consumed_valid", u_if.valid, 1'b0);
        check("ovr_consumed_data", u_if.data, 8'h3C);

        // Stop bit sampled low.
        f0 = ferr_cnt; r0 = rise_cnt;
        send_frame(8'h55, 1'b0);
        rxd = 1'b1;
        tick(1000);
        check("ferr_pulses", ferr_cnt - f0, 1);
        score("ferr");
        check("ferr_no_valid", rise_cnt - r0, 0);
        check("ferr_busy", u_if.busy, 1'b0);

        // Short low glitch on the line.
        f0 = ferr_cnt; r0 = rise_cnt;
        rxd = 1'b0;
        tick(50);
        check("glitch_busy_hi", u_if.busy, 1'b1);
        tick(50);
        rxd = 1'b1;
        tick(500);
        check("glitch_busy_lo", u_if.busy, 1'b0);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);

        // Reset in the middle of 0xF0's data bits, then a clean 0x0F.
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b0;
        tick(3 * CPB);
        check("midrst_busy_before", u_if.busy, 1'b1);
        rst = 1'b1;
        rxd = 1'b1;
        tick(3);
        check("midrst_data", u_if.data, 8'h00);
        check("midrst_valid", u_if.valid, 1'b0);
        check("midrst_busy", u_if.busy, 1'b0);
        check("midrst_ferr", u_if.frame_err, 1'b0);
        check("midrst_ovr", u_if.overrun, 1'b0);
        rst = 1'b0;
        tick(20);
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        tick(10);
        score("after_rst");
        check("after_rst_ferr", ferr_cnt - f0, 0);
        check("after_rst_ovr", ovr_cnt - o0, 0);

        // Back-to-back frames with no idle gap.
        v0 = valid_hi; f0 = ferr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(10);
        score("b2b");
        check("b2b_valid_cycles", valid_hi - v0, 2);
        check("b2b_ferr", ferr_cnt - f0, 0);

        // Final report
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 868; clock cycles per bit (115200 baud at 100 MHz); legal range 16..65535.
REQ-002 SHALL have port clk_100mhz, input, 1; the single clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1; synchronous, active-high reset.
REQ-004 SHALL have port uart_rxd, input, 1; asynchronous serial line, 8N1, idle high.
REQ-005 SHALL have port data_o, output, 8; received byte.
REQ-006 SHALL have port valid_o, output, 1; data_o holds an unconsumed byte.
REQ-007 SHALL have port ready_i, input, 1; the consumer accepts data_o when valid_o && ready_i.
REQ-008 SHALL have port frame_err_o, output, 1; one-cycle pulse when a stop bit samples 0.
REQ-009 SHALL have port overrun_o, output, 1; one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port busy_o, output, 1; high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass uart_rxd through a 2-flop synchronizer before any use; "rxs" below is the synchronizer output.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE SHALL move to START, with the baud counter cleared, in the cycle after rxs is first seen 0.
REQ-014 START SHALL sample rxs once the counter reaches CLOCKS_PER_BAUD/2-1 (integer division).
  - If rxs=0: go to DATA, clear counter, clear bit index.
  - If rxs=1: treat as a glitch and return to IDLE; no output activity.
REQ-015 DATA SHALL sample rxs every CLOCKS_PER_BAUD cycles after the start-bit sample, shifting the bits in LSB first; after bit index 7 it SHALL go to STOP.
REQ-016 STOP SHALL sample rxs CLOCKS_PER_BAUD cycles after bit 7, then return to IDLE in the next cycle.
  - If rxs=1: complete the byte.
  - If rxs=0: pulse frame_err_o and discard the byte.
REQ-017 A completed byte SHALL appear on data_o with valid_o=1 exactly 1 cycle after the stop-bit sample cycle.
REQ-018 valid_o and data_o SHALL stay stable until the cycle in which valid_o && ready_i holds; valid_o SHALL fall in the following cycle unless a new byte loads.
REQ-019 If a byte completes while valid_o=1 and ready_i=1 in the same cycle, the held byte SHALL be consumed and the new byte loaded; valid_o stays 1 and overrun_o stays 0.
REQ-020 If a byte completes while valid_o=1 and ready_i=0, the new byte SHALL be dropped, the held byte kept, and overrun_o pulsed.
REQ-021 ready_i SHALL have no effect while valid_o=0.
REQ-022 A new start bit SHALL be accepted in IDLE immediately after STOP, so back-to-back frames with no idle gap are received.
REQ-023 The baud counter SHALL be ceil(log2(CLOCKS_PER_BAUD)) bits wide and SHALL never wrap within a bit period.

Reset
REQ-024 While sys_rst=1, the following SHALL be forced at the next edge:
  - FSM to IDLE; counter and bit index to 0.
  - Synchronizer flops to 1.
  - data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; the first falling edge after reset release starts a fresh frame.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum and the constant DEFAULT_CLOCKS_PER_BAUD=868.
REQ-027 The synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value parameter set to 1); all other logic stays in uart_rx.

Verification
REQ-028 Byte 0xA5 at CLOCKS_PER_BAUD=868, ready_i=1 -> valid_o high for exactly 1 cycle with data_o=0xA5; frame_err_o=0, overrun_o=0.
REQ-029 ready_i=0, send 0x3C then 0x81 -> data_o stays 0x3C and overrun_o pulses once at the second stop sample; raise ready_i -> 0x3C consumed, valid_o falls.
REQ-030 Frame 0x55 with stop bit 0 -> frame_err_o pulses once; valid_o never rises.
REQ-031 uart_rxd low for 100 cycles (< 434) -> FSM returns to IDLE, busy_o falls, no valid_o/frame_err_o.
REQ-032 sys_rst pulsed during DATA of 0xF0 -> all outputs reset; the next frame 0x0F is received correctly.
REQ-033 Back-to-back 0x00, 0xFF with no idle gap, ready_i=1 -> two valid_o pulses carrying 0x00 then 0xFF.
